// File: rtl/serial_stream_piso_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
//   Shared definitions for the serial stream serializer and its helpers:
//   FSM state encoding, the default word width and the bit-counter width
//   helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package serial_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_SHIFT  = ST_SHIFT,
        S_PARITY = ST_PARITY
    } state_t;

    // Width of a counter that indexes WIDTH bit positions (at least 1 bit).
    function automatic int CNT_W(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_stream_piso_mod_n_counter.sv
// -----------------------------------------------------------------------------
// mod_n_counter
//   Loadable / clearable modulo-N up-counter with terminal-count flag.
//   Priority: clear > load > count enable. Counting past N-1 wraps to 0.
//
//   Ports:
//     clk         in   rising-edge clock
//     rst_n       in   asynchronous active-low reset (count -> 0)
//     i_clr       in   synchronous clear to 0
//     i_load      in   synchronous load of i_load_val
//     i_load_val  in   value loaded when i_load is high
//     i_en        in   count enable
//     o_cnt       out  current count
//     o_tc        out  high while o_cnt == N-1
// -----------------------------------------------------------------------------
module mod_n_counter #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] r_cnt;
    logic         w_tc;

    assign w_tc = (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en) begin
            r_cnt <= w_tc ? '0 : (r_cnt + W'(1));
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = w_tc;

endmodule

// File: rtl/serial_stream_piso.sv
// -----------------------------------------------------------------------------
// serial_stream_piso
//   Parallel-in / serial-out word serializer. A WIDTH-bit word is accepted on
//   a valid/ready handshake and streamed one bit per clock on ser_out, flagged
//   by ser_valid. A new word can be accepted during the last bit of the
//   previous one, so back-to-back words stream without gaps.
//
//   Optional feature macro: SERIAL_STREAM_PISO_PARITY_EN
//     defined   -> an even-parity bit (XOR of the data bits) follows each word
//     undefined -> words are exactly WIDTH cycles long, no parity logic
//
//   Parameters:
//     WIDTH      data word width (2..32)
//     MSB_FIRST  1: bit WIDTH-1 first, 0: bit 0 first
//
//   Ports:
//     clk        in   rising-edge clock
//     rst        in   asynchronous active-low reset
//     in_data    in   word to serialize, sampled on the accept edge
//     in_valid   in   in_data is presented
//     in_ready   out  block can accept a word this cycle (combinational)
//     ser_out    out  serial bit (registered)
//     ser_valid  out  ser_out carries a data or parity bit (registered)
//     word_done  out  cycle carries the last bit of a word (combinational)
// -----------------------------------------------------------------------------
module serial_stream_piso
    import serial_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done
);

    localparam int            CW       = CNT_W(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic             r_ser_out;
    logic             r_ser_valid;
`ifdef SERIAL_STREAM_PISO_PARITY_EN
    logic             r_par;
`endif

    logic [CW-1:0]    w_bit_cnt;
    logic             w_cnt_tc;
    logic             w_last_bit;
    logic             w_ready;
    logic             w_accept;
    logic             w_more_bits;
    logic             w_next_bit;

    // Move the register one position toward the output end.
    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? (v << 1) : (v >> 1);
    endfunction

    // Bit at the output end of a word in emission order.
    function automatic logic out_end(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    mod_n_counter #(
        .N (WIDTH),
        .W (CW)
    ) u_bit_cnt (
        .clk        (clk),
        .rst_n      (rst),
        .i_clr      (w_accept),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (r_state == S_SHIFT),
        .o_cnt      (w_bit_cnt),
        .o_tc       (w_cnt_tc)
    );

`ifdef SERIAL_STREAM_PISO_PARITY_EN
    assign w_last_bit = (r_state == S_PARITY);
`else
    assign w_last_bit = (r_state == S_SHIFT) & w_cnt_tc;
`endif

    // Ready during idle or while the final bit of a word is on the line; the
    // rst term keeps ready low for the whole time reset is asserted.
    assign w_ready  = rst & ((r_state == S_IDLE) | w_last_bit);
    assign w_accept = in_valid & w_ready;

    assign w_more_bits = (r_state == S_SHIFT) & (w_bit_cnt != LAST_CNT);
    assign w_next_bit  = out_end(r_shift);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (w_cnt_tc) begin
`ifdef SERIAL_STREAM_PISO_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = w_accept ? S_SHIFT : S_IDLE;
`endif
                end
            end
`ifdef SERIAL_STREAM_PISO_PARITY_EN
            S_PARITY: begin
                w_state_nxt = w_accept ? S_SHIFT : S_IDLE;
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The first bit goes straight to the output register on accept, so the
    // shift register holds the word already advanced by one position and its
    // output end is always the next bit to show.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift     <= '0;
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
`ifdef SERIAL_STREAM_PISO_PARITY_EN
            r_par       <= 1'b0;
`endif
        end else if (w_accept) begin
            r_shift     <= shift_one(in_data);
            r_ser_out   <= out_end(in_data);
            r_ser_valid <= 1'b1;
`ifdef SERIAL_STREAM_PISO_PARITY_EN
            r_par       <= ^in_data;
`endif
        end else if (w_more_bits) begin
            r_shift     <= shift_one(r_shift);
            r_ser_out   <= w_next_bit;
            r_ser_valid <= 1'b1;
`ifdef SERIAL_STREAM_PISO_PARITY_EN
        end else if (r_state == S_SHIFT) begin
            r_ser_out   <= r_par;
            r_ser_valid <= 1'b1;
`endif
        end else begin
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
        end
    end

    assign in_ready  = w_ready;
    assign ser_out   = r_ser_out;
    assign ser_valid = r_ser_valid;
    assign word_done = w_last_bit;

endmodule

// File: tb/tb_serial_stream_piso.sv
// -----------------------------------------------------------------------------
// tb_serial_stream_piso
//   Bench for serial_stream_piso. Two instances (MSB-first and LSB-first,
//   WIDTH=8) share one input stream. The reference model is a queue of the
//   bits each word must produce; the line is expected to show the head of
//   that queue every cycle, and the block is expected ready whenever at most
//   one bit remains queued.
// -----------------------------------------------------------------------------
module tb_serial_stream_piso;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;

    logic rdy_m, so_m, sv_m, wd_m;
    logic rdy_l, so_l, sv_l, wd_l;

    always #5 clk = ~clk;

    serial_stream_piso #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (rdy_m),
        .ser_out   (so_m),
        .ser_valid (sv_m),
        .word_done (wd_m)
    );

    serial_stream_piso #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (rdy_l),
        .ser_out   (so_l),
        .ser_valid (sv_l),
        .word_done (wd_l)
    );

`ifdef SERIAL_STREAM_PISO_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct packed {
        logic b;
        logic d;
    } ebit_t;

    ebit_t      qm[$];
    ebit_t      ql[$];
    int         n_assert = 0;
    int         n_fail   = 0;
    bit         last_acc;
    logic [7:0] cap_m, cap_l;
    int         vcount;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare this cycle's outputs with the model, then advance the model
    // across the coming rising edge.
    task automatic check_cycle();
        logic  er;
        ebit_t fm, fl;
        er = rst && (qm.size() <= 1);
        fm = (qm.size() > 0) ? qm[0] : '0;
        fl = (ql.size() > 0) ? ql[0] : '0;
        chk("m_ready", {7'd0, rdy_m}, {7'd0, er});
        chk("m_valid", {7'd0, sv_m},  {7'd0, qm.size() > 0});
        chk("m_out",   {7'd0, so_m},  {7'd0, fm.b});
        chk("m_done",  {7'd0, wd_m},  {7'd0, fm.d});
        chk("l_ready", {7'd0, rdy_l}, {7'd0, er});
        chk("l_valid", {7'd0, sv_l},  {7'd0, ql.size() > 0});
        chk("l_out",   {7'd0, so_l},  {7'd0, fl.b});
        chk("l_done",  {7'd0, wd_l},  {7'd0, fl.d});
        if (sv_m) begin
            cap_m = {cap_m[6:0], so_m};
            vcount++;
        end
        if (sv_l) cap_l = {cap_l[6:0], so_l};
        last_acc = in_valid && er;
        if (qm.size() > 0) void'(qm.pop_front());
        if (ql.size() > 0) void'(ql.pop_front());
        if (last_acc) begin
            for (int i = 0; i < 8; i++) begin
                qm.push_back(ebit_t'{b: in_data[7-i], d: (!PAR_EN && (i == 7))});
                ql.push_back(ebit_t'{b: in_data[i],   d: (!PAR_EN && (i == 7))});
            end
            if (PAR_EN) begin
                qm.push_back(ebit_t'{b: ^in_data, d: 1'b1});
                ql.push_back(ebit_t'{b: ^in_data, d: 1'b1});
            end
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        @(posedge clk);
        #1;
        in_valid = v;
        in_data  = d;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'h00);
    endtask

    // Hold in_valid with word d until the model sees it accepted.
    task automatic send(input logic [7:0] d);
        last_acc = 1'b0;
        for (int k = 0; k < 40 && !last_acc; k++) step(1'b1, d);
        n_assert++;
        assert (last_acc === 1'b1)
        else begin
            n_fail++;
            $error("FAIL send_timeout: word %0h observed not accepted expected accepted", d);
        end
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        cap_m    = '0;
        cap_l    = '0;
        vcount   = 0;

        // Reset state, then release: ready in the first cycle.
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_cycle();

        // Single word, both bit orders.
        send(8'hB4);
        idle(12);
`ifndef SERIAL_STREAM_PISO_PARITY_EN
        chk("b4_msb_stream", cap_m, 8'hB4);
        chk("b4_lsb_stream", cap_l, 8'h2D);
`endif

        // Back-to-back with in_valid held high.
        vcount = 0;
        send(8'hFF);
        send(8'h00);
        idle(12);
        chk("b2b_valid_cycles", vcount[7:0], 8'(2 * (8 + int'(PAR_EN))));

        // Parity-oriented words (plain words in the default build).
        send(8'h07);
        send(8'hB4);
        idle(12);

        // Stall: in_valid pulses away from the last bit are ignored.
        send(8'hA5);
        step(1'b0, 8'h00);
        step(1'b1, 8'h3C);
        step(1'b0, 8'h00);
        step(1'b1, 8'h3C);
        idle(12);

        // Reset in the middle of a word.
        send(8'hB4);
        idle(3);
        #2;
        rst = 1'b0;
        qm.delete();
        ql.delete();
        #1;
        chk("rst_m_out",   {7'd0, so_m},  8'h00);
        chk("rst_m_valid", {7'd0, sv_m},  8'h00);
        chk("rst_m_done",  {7'd0, wd_m},  8'h00);
        chk("rst_m_ready", {7'd0, rdy_m}, 8'h00);
        chk("rst_l_valid", {7'd0, sv_l},  8'h00);
        chk("rst_l_ready", {7'd0, rdy_l}, 8'h00);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_cycle();
        cap_m = '0;
        cap_l = '0;
        send(8'h81);
        idle(12);
`ifndef SERIAL_STREAM_PISO_PARITY_EN
        chk("post_rst_msb", cap_m, 8'h81);
        chk("post_rst_lsb", cap_l, 8'h81);
`endif

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 3) != 0), 8'($urandom));
        end
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_stream_piso.md
# serial_stream_piso

Parallel-in / serial-out word serializer that generates the single-bit `x_in` stream consumed by the team's serial sequence detectors. It accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock, registered and flagged by `ser_valid`. Back-to-back words are streamed gaplessly, so downstream detectors see an uninterrupted bit sequence.

## Interface
- `WIDTH`, 8: data word width in bits; legal range 2..32.
- `MSB_FIRST`, 1: 1 emits bit WIDTH-1 first; 0 emits bit 0 first.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `in_data`  in  WIDTH  word to serialize; sampled on the accept edge only.
- `in_valid`  in  1  `in_data` is presented.
- `in_ready`  out  1  block can accept a word this cycle.
- `ser_out`  out  1  serial bit, registered; feeds the detector's `x_in`.
- `ser_valid`  out  1  `ser_out` carries a word or parity bit.
- `word_done`  out  1  high during the cycle that carries the last bit of a word (the parity bit when parity is enabled).

## Operation
- Accept: rising edge with `in_valid & in_ready`; the word is latched into the shift register and the bit counter is cleared.
- States: IDLE, SHIFT, PARITY (PARITY exists only with the macro).
  - IDLE -> SHIFT on accept.
  - SHIFT emits bits 0..WIDTH-1 of the output order, one per cycle, with counter `bit_cnt` running 0..WIDTH-1.
  - SHIFT at `bit_cnt == WIDTH-1` goes to PARITY when enabled. Otherwise it goes to SHIFT with `bit_cnt = 0` on accept, or to IDLE.
  - PARITY goes to SHIFT on accept, otherwise to IDLE.
- `in_ready = rst & (state == IDLE | last_bit)`, where `last_bit` is the final bit cycle of the word (last data bit, or the parity bit when enabled). A new word is therefore accepted in the same cycle the previous word's last bit is shown, giving zero idle gap.
- Outside SHIFT/PARITY, `ser_out = 0` and `ser_valid = 0`.
- `in_valid` dropping while `in_ready` is low has no effect. The block never drops or duplicates a word.
- Reset (async assert, any state): state IDLE, shift register 0, `bit_cnt` 0, `ser_out` 0, `ser_valid` 0, `word_done` 0, `in_ready` 0. An in-flight word is discarded and not resumed.

## Timing
- Latency: accept on edge N puts the first bit on `ser_out` with `ser_valid = 1` during cycle N+1.
- A word occupies WIDTH cycles, or WIDTH+1 with parity.
- Sustained throughput: one word per WIDTH (or WIDTH+1) cycles, with no bubble when `in_valid` is held high.
- `word_done` and `in_ready` are combinational from state and counter. Every other output is registered.
- After reset deasserts, `in_ready` rises in the first cycle; the first accept is possible on the first edge.

## Configuration
- `SERIAL_STREAM_PISO_PARITY_EN`
  - Defined: even parity (XOR of all WIDTH data bits, computed at accept) is emitted as one extra `ser_valid` bit after the data bits, via the PARITY state. `word_done` marks the parity cycle.
  - Undefined: no PARITY state and no parity logic; words are WIDTH cycles long.

## Structure
- Shared package `serial_pkg`:
  - state encoding constants `ST_IDLE`, `ST_SHIFT`, `ST_PARITY` (2-bit);
  - counter width function `CNT_W = $clog2(WIDTH)`;
  - default WIDTH constant.
- One sub-module: `mod_n_counter`, a loadable/clearable modulo-N up-counter with a terminal-count output, which supplies `bit_cnt` and `last_bit`.
- Shift register, FSM and handshake logic stay in the top level.

## Test plan
- Reset then single word, WIDTH=8, MSB_FIRST=1, no parity: `in_data=8'hB4` -> `ser_out` 1,0,1,1,0,1,0,0 on cycles N+1..N+8. `word_done` is high only in cycle N+8. `ser_valid` falls and `ser_out=0` in cycle N+9.
- LSB-first: MSB_FIRST=0, `8'hB4` -> `ser_out` 0,0,1,0,1,1,0,1.
- Back-to-back: `in_valid` held high with `8'hFF` then `8'h00` -> 16 contiguous `ser_valid` cycles. Output is eight 1s then eight 0s. The second accept occurs at the edge closing cycle N+8 (`in_ready` high in that cycle).
- Parity enabled: `8'h07` -> 0,0,0,0,0,1,1,1 then parity bit 1. Then `8'hB4` -> data followed by parity 0. `word_done` is high only on each parity cycle, and each word lasts 9 cycles.
- Reset mid-word: assert `rst=0` after the 3rd bit of `8'hB4` -> all outputs 0 immediately. After release, `in_ready=1` in the first cycle, and the next word `8'h81` streams 1,0,0,0,0,0,0,1 with no residue from the aborted word.
- Backpressure/stall: `in_valid` pulses while SHIFT is not on its last bit -> not accepted, output stream unchanged. `in_valid=0` throughout -> `ser_valid` stays 0 and `ser_out` stays 0.
